// File: rtl/ex_mdu.sv
// MIPS execute stage: logic/move result path, HI/LO pair, single-cycle multiplier
// and a multi-cycle restoring divider that stalls the front of the pipeline.
module ex_mdu #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] OP_OR    = 8'b00100101;
  localparam logic [7:0] OP_AND   = 8'b00100100;
  localparam logic [7:0] OP_XOR   = 8'b00100110;
  localparam logic [7:0] OP_MFHI  = 8'b00010000;
  localparam logic [7:0] OP_MFLO  = 8'b00010010;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  div_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [31:0]      quo_r, quo_nxt_s;
  logic [31:0]      rem_r, rem_nxt_s;
  logic [31:0]      divisor_r, divisor_nxt_s;
  logic [31:0]      hi_r, lo_r;

  logic        is_mult_s, is_smult_s, is_div_s, is_sdiv_s;
  logic [63:0] mul_a_s, mul_b_s, product_s;
  logic [31:0] dividend_abs_s, divisor_abs_s;
  logic [32:0] rem_shift_s;
  logic [33:0] diff_s;
  logic [31:0] quo_final_s, rem_final_s;
  logic        commit_s;
  logic [31:0] logic_res_s, move_res_s;

  assign is_smult_s = (aluop_i == OP_MULT);
  assign is_mult_s  = is_smult_s || (aluop_i == OP_MULTU);
  assign is_sdiv_s  = (aluop_i == OP_DIV);
  assign is_div_s   = is_sdiv_s || (aluop_i == OP_DIVU);

  // Sign- or zero-extend to 64 bits so one truncated multiply serves both MULT and MULTU.
  assign mul_a_s   = is_smult_s ? {{32{reg1_i[31]}}, reg1_i} : {32'd0, reg1_i};
  assign mul_b_s   = is_smult_s ? {{32{reg2_i[31]}}, reg2_i} : {32'd0, reg2_i};
  assign product_s = mul_a_s * mul_b_s;

  assign dividend_abs_s = (is_sdiv_s && reg1_i[31]) ? neg32(reg1_i) : reg1_i;
  assign divisor_abs_s  = (is_sdiv_s && reg2_i[31]) ? neg32(reg2_i) : reg2_i;

  // quo_r holds the dividend and shifts quotient bits in from the right.
  assign rem_shift_s = {rem_r, quo_r[31]};
  assign diff_s      = {1'b0, rem_shift_s} - {2'b00, divisor_r};

  // Divider next-state and datapath.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    quo_nxt_s     = quo_r;
    rem_nxt_s     = rem_r;
    divisor_nxt_s = divisor_r;
    commit_s      = 1'b0;
    case (state_r)
      DIV_IDLE: begin
        if (is_div_s && !annul_i) begin
          if (reg2_i == 32'd0) begin
            state_nxt_s = DIV_BY_ZERO;
          end else begin
            quo_nxt_s     = dividend_abs_s;
            divisor_nxt_s = divisor_abs_s;
            rem_nxt_s     = 32'd0;
            cnt_nxt_s     = {CNT_W{1'b0}};
            state_nxt_s   = DIV_ON;
          end
        end else begin
          state_nxt_s = DIV_IDLE;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i || !is_div_s) begin
          state_nxt_s = DIV_IDLE;
        end else begin
          quo_nxt_s   = 32'd0;
          rem_nxt_s   = 32'd0;
          state_nxt_s = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i || !is_div_s) begin
          state_nxt_s = DIV_IDLE;
        end else begin
          if (diff_s[33]) begin
            rem_nxt_s = rem_shift_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b0};
          end else begin
            rem_nxt_s = diff_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b1};
          end
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          state_nxt_s = (cnt_r == CNT_LAST) ? DIV_END : DIV_ON;
        end
      end
      DIV_END: begin
        commit_s    = is_div_s && !annul_i;
        state_nxt_s = DIV_IDLE;
      end
      default: begin
        state_nxt_s = DIV_IDLE;
      end
    endcase
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    quo_final_s = quo_r;
    rem_final_s = rem_r;
    if (is_sdiv_s && (reg1_i[31] ^ reg2_i[31])) begin
      quo_final_s = neg32(quo_r);
    end else begin
      quo_final_s = quo_r;
    end
    if (is_sdiv_s && reg1_i[31]) begin
      rem_final_s = neg32(rem_r);
    end else begin
      rem_final_s = rem_r;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= DIV_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      quo_r     <= 32'd0;
      rem_r     <= 32'd0;
      divisor_r <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      quo_r     <= quo_nxt_s;
      rem_r     <= rem_nxt_s;
      divisor_r <= divisor_nxt_s;
    end
  end

  // HI/LO pair: written by a multiply or a completed divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (is_mult_s) begin
      hi_r <= product_s[63:32];
      lo_r <= product_s[31:0];
    end else if (commit_s) begin
      hi_r <= rem_final_s;
      lo_r <= quo_final_s;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Per-class result candidates.
  always_comb begin
    logic_res_s = 32'd0;
    move_res_s  = 32'd0;
    case (aluop_i)
      OP_OR:   logic_res_s = reg1_i | reg2_i;
      OP_AND:  logic_res_s = reg1_i & reg2_i;
      OP_XOR:  logic_res_s = reg1_i ^ reg2_i;
      default: logic_res_s = 32'd0;
    endcase
    case (aluop_i)
      OP_MFHI: move_res_s = hi_r;
      OP_MFLO: move_res_s = lo_r;
      default: move_res_s = 32'd0;
    endcase
  end

  // Write-back bundle and stall request; all quiet while reset is asserted.
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      stallreq_o = 1'b0;
    end else begin
      wd_o       = wd_i;
      wreg_o     = wreg_i && !(is_mult_s || is_div_s);
      stallreq_o = is_div_s && (state_r != DIV_END);
      case (alusel_i)
        SEL_LOGIC: wdata_o = logic_res_s;
        SEL_MOVE:  wdata_o = move_res_s;
        default:   wdata_o = 32'd0;
      endcase
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed plus randomized bench for ex_mdu against an arithmetic reference model.
module tb_ex_mdu;

  localparam logic [7:0] OP_NOP   = 8'b00000000;
  localparam logic [7:0] OP_OR    = 8'b00100101;
  localparam logic [7:0] OP_AND   = 8'b00100100;
  localparam logic [7:0] OP_XOR   = 8'b00100110;
  localparam logic [7:0] OP_MFHI  = 8'b00010000;
  localparam logic [7:0] OP_MFLO  = 8'b00010010;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, annul;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_mdu #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .annul_i(annul),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: whole-number arithmetic, truncating division, wrap to 32 bits.
  function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (op == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] ref_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] ua, ub;
    if (op == OP_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] ref_logic(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    aluop = op; alusel = SEL_NOP; reg1 = a; reg2 = b; wreg = 1'b1; wd = 5'd9;
    #1;
    chk("mul_wreg_forced_low", {31'd0, wreg_o}, 32'd0);
    tick();
    p = ref_mul(op, a, b);
    m_hi = p[63:32];
    m_lo = p[31:0];
    aluop = OP_NOP;
    #1;
    chk("mul_hi", hi_o, m_hi);
    chk("mul_lo", lo_o, m_lo);
  endtask

  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] r;
    n = 0;
    aluop = op; alusel = SEL_NOP; reg1 = a; reg2 = b; wreg = 1'b1; wd = 5'd3;
    #1;
    while (stallreq_o === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("div_stall_cycles", 32'(n), (b == 32'd0) ? 32'd2 : 32'd33);
    chk("div_wreg_forced_low", {31'd0, wreg_o}, 32'd0);
    chk("div_hilo_before_commit", hi_o ^ lo_o, m_hi ^ m_lo);
    tick();
    r = ref_div(op, a, b);
    m_hi = r[63:32];
    m_lo = r[31:0];
    aluop = OP_NOP;
    #1;
    chk("div_hi", hi_o, m_hi);
    chk("div_lo", lo_o, m_lo);
  endtask

  task automatic do_move(input logic [7:0] op);
    aluop = op; alusel = SEL_MOVE; wreg = 1'b1; wd = 5'd12;
    #1;
    chk("move_wdata", wdata_o, (op == OP_MFHI) ? m_hi : m_lo);
    chk("move_wreg", {31'd0, wreg_o}, 32'd1);
    tick();
  endtask

  task automatic do_logic(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    aluop = op; alusel = SEL_LOGIC; reg1 = a; reg2 = b; wd = d; wreg = 1'b1;
    #1;
    chk("logic_wdata", wdata_o, ref_logic(op, a, b));
    chk("logic_wd", {27'd0, wd_o}, {27'd0, d});
    chk("logic_stall", {31'd0, stallreq_o}, 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] ra, rb;
    int kind;

    rst = 1'b1; aluop = OP_OR; alusel = SEL_LOGIC; reg1 = 32'h0000F0F0; reg2 = 32'h00000F0F;
    wd = 5'd5; wreg = 1'b1; annul = 1'b0;
    #3;
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    aluop = OP_DIV;
    #1;
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    aluop = OP_OR;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed OR with wd/wreg passthrough
    chk("or_wdata", wdata_o, 32'h0000FFFF);
    chk("or_wd", {27'd0, wd_o}, 32'd5);
    chk("or_wreg", {31'd0, wreg_o}, 32'd1);
    chk("or_stall", {31'd0, stallreq_o}, 32'd0);
    tick();

    do_mul(OP_MULT, 32'hFFFFFFFD, 32'd5);
    chk("mult_neg3x5_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_neg3x5_lo", lo_o, 32'hFFFFFFF1);
    do_move(OP_MFLO);
    do_move(OP_MFHI);

    do_div(OP_DIVU, 32'd100, 32'd7);
    chk("divu_100_7_lo", lo_o, 32'd14);
    chk("divu_100_7_hi", hi_o, 32'd2);
    do_div(OP_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_m7_2_lo", lo_o, 32'hFFFFFFFD);
    chk("div_m7_2_hi", hi_o, 32'hFFFFFFFF);
    do_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min_m1_lo", lo_o, 32'h80000000);
    chk("div_min_m1_hi", hi_o, 32'd0);

    // Preload HI = LO = 0x1234 (0x1234 * (2^32 + 1)), then divide by zero
    do_mul(OP_MULTU, 32'd2987060, 32'd6700417);
    chk("preload_hi", hi_o, 32'h00001234);
    chk("preload_lo", lo_o, 32'h00001234);
    do_div(OP_DIV, 32'd9, 32'd0);
    chk("divzero_hi", hi_o, 32'd0);
    chk("divzero_lo", lo_o, 32'd0);

    // Asynchronous reset in the middle of ON cycle 10
    do_mul(OP_MULT, 32'h00012345, 32'h00054321);
    aluop = OP_DIVU; alusel = SEL_NOP; reg1 = 32'd100; reg2 = 32'd7;
    for (int i = 0; i < 11; i++) tick();
    chk("pre_rst_stall", {31'd0, stallreq_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("mid_rst_hi", hi_o, 32'd0);
    chk("mid_rst_lo", lo_o, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    aluop = OP_NOP;
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_div(OP_DIVU, 32'd100, 32'd7);

    // Annul during ON: back to IDLE, HI/LO untouched
    do_mul(OP_MULTU, 32'hCAFEBABE, 32'h00000010);
    aluop = OP_DIV; alusel = SEL_NOP; reg1 = 32'd1000; reg2 = 32'd3;
    for (int i = 0; i < 6; i++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    aluop = OP_NOP;
    #1;
    chk("annul_stall", {31'd0, stallreq_o}, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("annul_hi", hi_o, m_hi);
    chk("annul_lo", lo_o, m_lo);
    do_div(OP_DIV, 32'd1000, 32'hFFFFFFFD);

    // Randomized mix against the reference model
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      ra = $urandom();
      rb = $urandom();
      case (kind)
        0: begin
          case ($urandom_range(0, 2))
            0: do_logic(OP_OR, ra, rb, 5'($urandom_range(0, 31)));
            1: do_logic(OP_AND, ra, rb, 5'($urandom_range(0, 31)));
            default: do_logic(OP_XOR, ra, rb, 5'($urandom_range(0, 31)));
          endcase
        end
        1: do_mul(($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU, ra, rb);
        2: begin
          case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: rb = rb >> $urandom_range(1, 30);
            default: rb = rb;
          endcase
          do_div(($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU, ra, rb);
        end
        default: do_move(($urandom_range(0, 1) == 0) ? OP_MFHI : OP_MFLO);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Execute stage of the five-stage MIPS pipeline. It consumes the decoded bundle that the decode stage produces: aluop, alusel, operand values, destination address and write enable.
- It produces the EX-stage write-back bundle, which returns to the decode stage as its EX forwarding source (ex_wreg/ex_wdata/ex_wd).
- It contains the HI/LO register pair, a single-cycle 32x32 multiplier, and a 32-cycle radix-2 divider.
- While a divide is in flight, the divider stalls the front of the pipeline through stallreq_o.

Parameters:
- DIV_CYCLES, 32, number of quotient-bit iterations; fixed equal to operand width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- aluop_i  in  8  operation code from ID/EX register.
- alusel_i  in  3  result-class select from ID/EX register.
- reg1_i  in  32  operand 1 (dividend / multiplicand).
- reg2_i  in  32  operand 2 (divisor / multiplier).
- wd_i  in  5  destination GPR address.
- wreg_i  in  1  GPR write enable.
- annul_i  in  1  flush; aborts an in-flight divide.
- wd_o  out  5  destination address to EX/MEM and the ID forward path.
- wreg_o  out  1  GPR write enable to EX/MEM and the ID forward path.
- wdata_o  out  32  GPR write data to EX/MEM and the ID forward path.
- stallreq_o  out  1  request to hold PC, IF/ID and ID/EX.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.

Behaviour:
- Opcodes:
  - OR 8'b00100101, AND 8'b00100100, XOR 8'b00100110.
  - MFHI 8'b00010000, MFLO 8'b00010010.
  - MULT 8'b00011000, MULTU 8'b00011001.
  - DIV 8'b00011010, DIVU 8'b00011011.
  - Any other aluop is a NOP.
- Result classes (alusel): LOGIC 3'b001, MOVE 3'b011, NOP 3'b000.
- Result path (combinational):
  - wd_o = wd_i. wdata_o = logic result when alusel = LOGIC, HI/LO when alusel = MOVE, else 0.
  - wreg_o = wreg_i, except that it is forced to 0 for MULT/MULTU/DIV/DIVU.
- Reset (rst high, asynchronous): HI = LO = 0, divider state IDLE, counter 0. While rst is high, wd_o = 0, wreg_o = 0, wdata_o = 0 and stallreq_o = 0.
- MULT/MULTU:
  - Computes the 64-bit product (signed or unsigned) combinationally.
  - HI = product[63:32] and LO = product[31:0], written at the end of the same cycle.
  - An MFHI/MFLO in the next cycle sees the new value.
- Divider FSM: states IDLE, BY_ZERO, ON, END.
  - IDLE:
    - With DIV/DIVU present and reg2_i = 0: go to BY_ZERO.
    - With DIV/DIVU present and reg2_i nonzero: latch |dividend| and |divisor| (raw values for DIVU), clear the partial remainder, counter = 0, go to ON.
  - BY_ZERO: quotient = 0, remainder = 0; go to END.
  - ON: each cycle performs one restoring shift-subtract step and increments the counter. After DIV_CYCLES steps, go to END.
  - END:
    - For DIV only: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
    - Commit LO = quotient and HI = remainder at the clock edge, then go to IDLE.
- stallreq_o = 1 when aluop_i is DIV/DIVU and the state is not END; 0 otherwise.
  - Nonzero divide: stall for 33 cycles, results committed at the end of cycle 34.
  - Divide by zero: stall for 2 cycles, results committed at the end of cycle 3.
- Upstream holds the inputs stable while stallreq_o = 1. A new DIV arriving in the cycle after END starts fresh from IDLE.
- annul_i = 1, or aluop_i leaving DIV/DIVU while in ON/BY_ZERO: return to IDLE next edge with no HI/LO write.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wrap, no trap).
- A MULT in the same cycle as a divider END cannot occur, because the pipeline is serialised by the stall.

Test Plan:
- OR reg1 = 0x0000F0F0, reg2 = 0x00000F0F, alusel LOGIC, wd = 5, wreg = 1 -> same cycle wdata_o = 0x0000FFFF, wd_o = 5, wreg_o = 1, stallreq_o = 0.
- MULT reg1 = 0xFFFFFFFD (-3), reg2 = 5, wreg_i = 1 -> wreg_o = 0; next cycle hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFF1; then MFLO -> wdata_o = 0xFFFFFFF1.
- DIVU reg1 = 100, reg2 = 7, held -> stallreq_o high for exactly 33 cycles, low in cycle 34; after that edge lo_o = 14, hi_o = 2.
- DIV reg1 = 0xFFFFFFF9 (-7), reg2 = 2 -> lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_o = 0x80000000, hi_o = 0.
- DIV reg1 = 9, reg2 = 0 with HI/LO preloaded to 0x1234 -> stallreq_o high for 2 cycles, then hi_o = lo_o = 0.
- DIVU 100/7, with rst asserted in ON cycle 10 (asynchronously, mid-cycle) -> stallreq_o = 0 immediately, hi_o = lo_o = 0. After release, a re-issued DIVU completes normally in 34 cycles. Separately, annul_i in ON -> IDLE with HI/LO unchanged.
